// File: rtl/memory_access_unit.sv
// memory_access_unit: MEM stage of the pipelined MIPS core.
//
// This stage takes the latched EX results and does three things:
//   - performs data-memory loads and stores (byte, half or word, signed or
//     unsigned) on a word-organised array with per-byte write enables;
//   - resolves branches combinationally (o_pc_src, o_branch_target);
//   - latches the MEM/WB pipeline register that feeds write-back.
//
// Ports:
//   i_clock, i_reset          clock (rising edge); asynchronous active-high reset
//   i_alu_result              byte address for memory ops, else the write-back value
//   i_alu_zero, i_branch_addr EX zero flag and branch target
//   i_store_data              rt value to store
//   i_wb_reg_addr, i_reg_write destination register and its write enable
//   i_mem_read, i_mem_write   load / store
//   i_mem_width               00 byte, 01 half, 10/11 word
//   i_load_unsigned           zero-extend byte/half loads
//   i_branch, i_branch_ne     branch instruction; BEQ (0) or BNE (1)
//   o_pc_src, o_branch_target branch decision and target (combinational)
//   o_*_ltchd                 MEM/WB register outputs
//
// Optional feature: define MEM_DEBUG_PORT_EN to add i_dbg_addr / o_dbg_data,
// an asynchronous word read port into the array for the debug unit.
module memory_access_unit #(
    parameter int NB_ADDR      = 5,
    parameter int NB_DATA      = 32,
    parameter int NB_MEM_ADDR  = 8,
    parameter int NB_WIDTH_SEL = 2
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [NB_DATA-1:0]      i_alu_result,
    input  logic                    i_alu_zero,
    input  logic [NB_DATA-1:0]      i_branch_addr,
    input  logic [NB_DATA-1:0]      i_store_data,
    input  logic [NB_ADDR-1:0]      i_wb_reg_addr,
    input  logic                    i_reg_write,
    input  logic                    i_mem_read,
    input  logic                    i_mem_write,
    input  logic [NB_WIDTH_SEL-1:0] i_mem_width,
    input  logic                    i_load_unsigned,
    input  logic                    i_branch,
    input  logic                    i_branch_ne,
`ifdef MEM_DEBUG_PORT_EN
    input  logic [NB_MEM_ADDR-1:0]  i_dbg_addr,
    output logic [NB_DATA-1:0]      o_dbg_data,
`endif
    output logic                    o_pc_src,
    output logic [NB_DATA-1:0]      o_branch_target,
    output logic [NB_DATA-1:0]      o_wb_data_ltchd,
    output logic [NB_ADDR-1:0]      o_wb_reg_addr_ltchd,
    output logic                    o_wb_reg_write_ltchd,
    output logic                    o_mem_fault_ltchd
);

    localparam int DEPTH = 2 ** NB_MEM_ADDR;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;

    logic [NB_DATA-1:0] mem_q [DEPTH];

    logic [NB_MEM_ADDR-1:0] word_idx;
    logic [1:0]             lane;
    logic [1:0]             width;
    logic                   misaligned;
    logic                   store_en;
    logic [3:0]             byte_en;
    logic [NB_DATA-1:0]     wr_word;
    logic [NB_DATA-1:0]     rd_word;
    logic [NB_DATA-1:0]     rd_shift;
    logic [NB_DATA-1:0]     load_data;

    logic [NB_DATA-1:0]     wb_data_d;
    logic [NB_ADDR-1:0]     wb_reg_addr_d;
    logic                   wb_reg_write_d;
    logic                   mem_fault_d;

    // Address bits above the word index are ignored: the array wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_alu_result[NB_DATA-1:NB_MEM_ADDR+2];

    assign word_idx = i_alu_result[NB_MEM_ADDR+1:2];
    assign lane     = i_alu_result[1:0];
    assign width    = 2'(i_mem_width);

    // Encoding 11 falls into the word case along with 10.
    always_comb begin
        misaligned = 1'b0;
        byte_en    = 4'b1111;
        wr_word    = i_store_data;
        case (width)
            W_BYTE: begin
                byte_en = 4'b0001 << lane;
                wr_word = {4{i_store_data[7:0]}};
            end
            W_HALF: begin
                misaligned = lane[0];
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                wr_word    = {2{i_store_data[15:0]}};
            end
            default: begin
                misaligned = (lane != 2'b00);
            end
        endcase
    end

    assign store_en = i_mem_write & ~misaligned;

    // Same-edge write; reset held at the edge blocks the write.
    always_ff @(posedge i_clock) begin
        if (!i_reset && store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    // Asynchronous read sees the pre-store contents during a store cycle.
    assign rd_word  = mem_q[word_idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        case (width)
            W_BYTE:  load_data = i_load_unsigned ? {24'd0, rd_shift[7:0]}
                                                 : {{24{rd_shift[7]}}, rd_shift[7:0]};
            W_HALF:  load_data = i_load_unsigned ? {16'd0, rd_shift[15:0]}
                                                 : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_data = rd_word;
        endcase
        if (misaligned) begin
            load_data = '0;
        end
    end

    always_comb begin
        wb_data_d      = i_mem_read ? load_data : i_alu_result;
        wb_reg_addr_d  = i_wb_reg_addr;
        // A faulting load, or a load colliding with a store, must not retire a write.
        wb_reg_write_d = i_reg_write & ~(i_mem_read & (misaligned | i_mem_write));
        mem_fault_d    = ((i_mem_read | i_mem_write) & misaligned)
                       | (i_mem_read & i_mem_write);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_wb_data_ltchd      <= '0;
            o_wb_reg_addr_ltchd  <= '0;
            o_wb_reg_write_ltchd <= 1'b0;
            o_mem_fault_ltchd    <= 1'b0;
        end else begin
            o_wb_data_ltchd      <= wb_data_d;
            o_wb_reg_addr_ltchd  <= wb_reg_addr_d;
            o_wb_reg_write_ltchd <= wb_reg_write_d;
            o_mem_fault_ltchd    <= mem_fault_d;
        end
    end

    assign o_pc_src        = i_branch & (i_alu_zero ^ i_branch_ne);
    assign o_branch_target = i_branch_addr;

`ifdef MEM_DEBUG_PORT_EN
    assign o_dbg_data = mem_q[i_dbg_addr];
`endif

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
MEM stage of the pipelined MIPS core. It sits directly downstream of the execution stage and consumes that stage's latched ALU result, zero flag and branch address. It performs data-memory loads and stores (byte, half and word, signed or unsigned), resolves branches, and latches the MEM/WB pipeline register that feeds write-back.

Parameters:
NB_ADDR, 5, register-file address width.
NB_DATA, 32, datapath width; must be 32.
NB_MEM_ADDR, 8, data-memory word-index width; depth is 2**NB_MEM_ADDR words.
NB_WIDTH_SEL, 2, access-width selector width.

Ports:
i_clock  in  1  pipeline clock; rising edge active.
i_reset  in  1  asynchronous, active-high reset.
i_alu_result  in  NB_DATA  latched EX result; this is the byte address for memory operations.
i_alu_zero  in  1  latched EX zero flag.
i_branch_addr  in  NB_DATA  latched EX branch target.
i_store_data  in  NB_DATA  rt value to store.
i_wb_reg_addr  in  NB_ADDR  destination register.
i_reg_write  in  1  instruction writes the register file.
i_mem_read  in  1  load.
i_mem_write  in  1  store.
i_mem_width  in  NB_WIDTH_SEL  00 byte, 01 half, 10 word, 11 treated as word.
i_load_unsigned  in  1  zero-extend byte/half loads; 0 sign-extends.
i_branch  in  1  branch instruction.
i_branch_ne  in  1  0 = BEQ (taken on zero), 1 = BNE (taken on not zero).
o_pc_src  out  1  branch taken; combinational.
o_branch_target  out  NB_DATA  i_branch_addr passed through; combinational.
o_wb_data_ltchd  out  NB_DATA  load data or ALU result.
o_wb_reg_addr_ltchd  out  NB_ADDR  latched destination register.
o_wb_reg_write_ltchd  out  1  latched write enable.
o_mem_fault_ltchd  out  1  one-cycle misalignment/conflict flag.

Behaviour:
- Reset: all *_ltchd outputs go to 0 asynchronously. Memory contents are not cleared. If reset is asserted on a clock edge, no write occurs at that edge.
- Addressing: word index = i_alu_result[NB_MEM_ADDR+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*2**NB_MEM_ADDR bytes. Byte lane = i_alu_result[1:0], little-endian.
- Reads are asynchronous from the array. Writes are synchronous at the rising edge, with per-byte enables.
  - Byte store: writes i_store_data[7:0] into the selected lane.
  - Half store: writes [15:0] into lanes {1,0} or {3,2}.
  - Word store: writes all four lanes.
  - Unselected lanes are unchanged.
- Load extraction:
  - Byte/half loads are sign-extended, or zero-extended when i_load_unsigned=1.
  - Word loads ignore i_load_unsigned.
- Latency: 1 cycle. Inputs present in cycle N appear on the *_ltchd outputs after edge N+1.
  - o_wb_data_ltchd = extracted load data if i_mem_read, else i_alu_result.
- Same-address ordering: a load in the same cycle as a store to the same word returns the pre-store contents. A load in the following cycle returns the new contents.
- Misalignment: half access with addr[0]=1, or word access with addr[1:0]!=0.
  - Store: suppressed.
  - Load: returns 0 and o_wb_reg_write_ltchd=0.
  - o_mem_fault_ltchd=1 for exactly one cycle.
- i_mem_read and i_mem_write both 1: the store is performed if aligned, o_wb_reg_write_ltchd=0, and o_mem_fault_ltchd=1.
- Branch: o_pc_src = i_branch & (i_alu_zero ^ i_branch_ne). It is purely combinational and valid in the same cycle.
- Non-memory instructions (read=write=0) never touch the array and never raise a fault.

Optional Feature:
Macro MEM_DEBUG_PORT_EN.
- Defined: adds port i_dbg_addr (in, NB_MEM_ADDR, word index) and port o_dbg_data (out, NB_DATA). o_dbg_data is an asynchronous word read of the array for the debug unit. It has no effect on pipeline behaviour and shows a write after the write edge.
- Undefined: neither port exists and no extra logic is built.

Test Plan:
- Reset mid-run: assert i_reset during a store to addr 0x10 → outputs 0 immediately; word 4 is unchanged; after release, a load from 0x10 returns its old value.
- Word store then load: SW 0xDEADBEEF @0x08, next cycle LW @0x08 → o_wb_data_ltchd=0xDEADBEEF one cycle later, o_wb_reg_write_ltchd=1.
- Byte/half lanes: SB 0x80 @0x0B onto word 0x11223344 → word reads 0x80223344; LB @0x0B → 0xFFFFFF80; LBU → 0x00000080; LH @0x0A → 0xFFFF8022.
- Misaligned: LW @0x06 → o_mem_fault_ltchd=1 for one cycle, o_wb_reg_write_ltchd=0, data 0; SH @0x05 leaves memory unchanged.
- Branch: i_branch=1, i_branch_ne=0, i_alu_zero=1, i_branch_addr=0x40 → o_pc_src=1 same cycle, o_branch_target=0x40; with i_branch_ne=1 → o_pc_src=0.
- Wrap/ALU passthrough: with NB_MEM_ADDR=8, SW @0x400 aliases @0x000; a non-memory op with result 0x1234 → o_wb_data_ltchd=0x1234 and no array change.
